booth_seq_mult: RTL and testbench



---
 rtl/booth_seq_mult.sv | 208 ++++++++++++++++++++
 tb/tb_booth_seq_mult.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_mult.sv
// -----------------------------------------------------------------------------
// booth_seq_mult
//
// Iterative signed radix-4 Booth multiplier. An operand pair is accepted with a
// valid/ready handshake. One Booth digit of the multiplier is retired per clock.
// Each digit's partial product is accumulated into a 2*WIDTH-bit sum. The
// finished product is held on the output until the consumer takes it.
//
// Latency is fixed at WIDTH/2 CALC cycles. There is no early exit on zero
// digits. With OutReady tied high the core accepts one pair every WIDTH/2+2
// cycles: the IDLE accept cycle, WIDTH/2 CALC cycles and one DONE cycle.
//
// Parameters
//   WIDTH        operand width. It must be even and at least 4.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   InValid      operand pair valid
//   InReady      core can accept operands (high only in IDLE)
//   Multiplicant signed multiplicand A, captured at accept
//   Multiplier   signed multiplier B, captured at accept
//   OutValid     Product valid (high only in DONE)
//   OutReady     consumer accepts Product
//   Product      signed A*B, registered, holds the last result in IDLE
//   Busy         high in CALC or DONE
// -----------------------------------------------------------------------------
module booth_seq_mult #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               InValid,
    output logic               InReady,
    input  logic [WIDTH-1:0]   Multiplicant,
    input  logic [WIDTH-1:0]   Multiplier,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [2*WIDTH-1:0] Product,
    output logic               Busy
);

    localparam int NDIG = WIDTH / 2;                      // Booth digits per operand
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;  // digit index width
    localparam int PPW  = WIDTH + 2;                      // +/-2A needs two extra bits
    localparam int PW   = 2 * WIDTH;                      // product width

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t            state_reg,   state_next;
    logic [WIDTH-1:0]  a_reg,       a_next;
    logic [WIDTH-1:0]  b_reg,       b_next;
    logic [PW-1:0]     acc_reg,     acc_next;
    logic [IDXW-1:0]   idx_reg,     idx_next;
    logic [PW-1:0]     product_reg, product_next;

    // -------------------------------------------------------------------------
    // Booth recoding of every digit position of the latched multiplier.
    // Each digit is reduced to three control bits:
    //   neg  digit is negative (-1 or -2)
    //   one  |digit| == 1
    //   two  |digit| == 2
    // A zero digit has one = two = 0. The neg bit is then irrelevant because
    // the magnitude is zero.
    // -------------------------------------------------------------------------
    logic [NDIG-1:0] dig_neg;
    logic [NDIG-1:0] dig_one;
    logic [NDIG-1:0] dig_two;

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
        logic [2:0] trip;

        if (gi == 0) begin : g_first
            // The implicit bit below the LSB of B is zero.
            assign trip = {b_reg[1], b_reg[0], 1'b0};
        end else begin : g_rest
            assign trip = b_reg[2*gi+1 -: 3];
        end

        // Triplets 100, 101 and 110 are negative. Triplet 111 is zero.
        assign dig_neg[gi] = trip[2] & ~(trip[1] & trip[0]);
        // Triplets 001, 010, 101 and 110 have magnitude 1.
        assign dig_one[gi] = trip[1] ^ trip[0];
        // Triplets 011 and 100 have magnitude 2.
        assign dig_two[gi] = (trip == 3'b011) | (trip == 3'b100);
    end

    // -------------------------------------------------------------------------
    // Partial product for the current digit
    // -------------------------------------------------------------------------
    logic              cur_neg;
    logic              cur_one;
    logic              cur_two;
    logic [PPW-1:0]    a_ext;     // A sign-extended to PPW bits
    logic [PPW-1:0]    pp_mag;    // 0, A or 2A
    logic [PPW-1:0]    pp;        // digit * A, exact two's complement
    logic [PW-1:0]     pp_ext;    // pp sign-extended to the product width
    logic [PW-1:0]     pp_shift;  // pp weighted by 4^idx
    logic [PW-1:0]     acc_sum;
    logic [IDXW:0]     shamt;

    assign cur_neg = dig_neg[idx_reg];
    assign cur_one = dig_one[idx_reg];
    assign cur_two = dig_two[idx_reg];

    assign a_ext = {{2{a_reg[WIDTH-1]}}, a_reg};

    always_comb begin
        pp_mag = '0;
        if (cur_two) begin
            pp_mag = {a_ext[PPW-2:0], 1'b0};
        end else if (cur_one) begin
            pp_mag = a_ext;
        end
    end

    // The full negation is done here, including the +1. This keeps each
    // partial product self-contained. PPW bits hold +2^WIDTH, which is
    // -2 * (-2^(WIDTH-1)), so the negation cannot overflow.
    assign pp       = cur_neg ? (PPW'(0) - pp_mag) : pp_mag;
    assign pp_ext   = {{(PW - PPW){pp[PPW-1]}}, pp};
    assign shamt    = {idx_reg, 1'b0};
    assign pp_shift = pp_ext << shamt;
    // Wraps modulo 2^PW. The final sum is still the exact signed product.
    assign acc_sum  = acc_reg + pp_shift;

    // -------------------------------------------------------------------------
    // Next-state and datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        acc_next     = acc_reg;
        idx_next     = idx_reg;
        product_next = product_reg;

        unique case (state_reg)
            S_IDLE: begin
                if (InValid) begin
                    a_next     = Multiplicant;
                    b_next     = Multiplier;
                    acc_next   = '0;
                    idx_next   = '0;
                    state_next = S_CALC;
                end
            end

            S_CALC: begin
                acc_next = acc_sum;
                idx_next = idx_reg + IDXW'(1);
                if (idx_reg == LAST_IDX) begin
                    product_next = acc_sum;
                    state_next   = S_DONE;
                end
            end

            S_DONE: begin
                if (OutReady) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers. Reset takes priority over every handshake on the same edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            acc_reg     <= '0;
            idx_reg     <= '0;
            product_reg <= '0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            acc_reg     <= acc_next;
            idx_reg     <= idx_next;
            product_reg <= product_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, decoded from the registered state
    // -------------------------------------------------------------------------
    assign InReady  = (state_reg == S_IDLE);
    assign OutValid = (state_reg == S_DONE);
    assign Busy     = (state_reg != S_IDLE);
    assign Product  = product_reg;

endmodule

// File: tb/tb_booth_seq_mult.sv
// -----------------------------------------------------------------------------
// tb_booth_seq_mult
//
// Self-checking bench for booth_seq_mult (WIDTH = 16). It applies a table of
// directed operand pairs with hand-computed products. It then runs these
// sequences:
//   - an output stall with operands offered during the stall
//   - a reset in the middle of a calculation
//   - random pairs with random output stalls
// -----------------------------------------------------------------------------
module tb_booth_seq_mult;

    localparam int WIDTH = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               InValid;
    logic               InReady;
    logic [WIDTH-1:0]   Multiplicant;
    logic [WIDTH-1:0]   Multiplier;
    logic               OutValid;
    logic               OutReady;
    logic [2*WIDTH-1:0] Product;
    logic               Busy;

    int tests = 0;
    int fails = 0;

    booth_seq_mult #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .InValid      (InValid),
        .InReady      (InReady),
        .Multiplicant (Multiplicant),
        .Multiplier   (Multiplier),
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .Product      (Product),
        .Busy         (Busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one multiplication and holds OutReady low for 'stall' DONE cycles.
    // Returns the product and the number of cycles from accept to OutValid.
    // The operand inputs are scrambled after accept to show they are latched.
    task automatic do_mult(input logic [15:0] a, input logic [15:0] b, input int stall,
                           output logic [31:0] prod, output int lat);
        int n;
        logic [31:0] p0;
        n = 0;
        while (!InReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", InReady, 1'b1);
        InValid      = 1'b1;
        Multiplicant = a;
        Multiplier   = b;
        OutReady     = (stall == 0);
        @(negedge clk);
        InValid      = 1'b0;
        Multiplicant = 16'($urandom);
        Multiplier   = 16'($urandom);
        check("in_ready_drop", InReady, 1'b0);
        lat = 1;
        while (!OutValid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid_seen", OutValid, 1'b1);
        prod = Product;
        for (int s = 0; s < stall; s++) begin
            p0 = Product;
            @(negedge clk);
            check("stall_hold", {OutValid, Product}, {1'b1, p0});
        end
        OutReady = 1'b1;
        @(negedge clk);
        check("out_valid_drop", OutValid, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] prod;
        int          lat;
        int          n;
        bit          pulse;
        logic [15:0] ra, rb;
        logic [31:0] rexp;

        // Directed vectors: {A, B, A*B}
        vecs[0]  = '{16'h0003, 16'h0005, 32'h0000000F};
        vecs[1]  = '{16'h8000, 16'h8000, 32'h40000000};
        vecs[2]  = '{16'h8000, 16'h7FFF, 32'hC0008000};
        vecs[3]  = '{16'hFFF9, 16'h5555, 32'hFFFDAAAD};  // -7 * 21845
        vecs[4]  = '{16'hFFF9, 16'hAAAA, 32'h0002555A};  // -7 * -21846
        vecs[5]  = '{16'h0000, 16'h1234, 32'h00000000};
        vecs[6]  = '{16'hFFFF, 16'hFFFF, 32'h00000001};
        vecs[7]  = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
        vecs[8]  = '{16'h8000, 16'h0001, 32'hFFFF8000};
        vecs[9]  = '{16'h04D2, 16'h162E, 32'h006AE9BC};  // 1234 * 5678
        vecs[10] = '{16'hFB2E, 16'h162E, 32'hFF951644};  // -1234 * 5678
        vecs[11] = '{16'h0002, 16'hFFFD, 32'hFFFFFFFA};

        rst          = 1'b1;
        InValid      = 1'b0;
        OutReady     = 1'b1;
        Multiplicant = '0;
        Multiplier   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("reset_in_ready",  InReady,  1'b1);
        check("reset_out_valid", OutValid, 1'b0);
        check("reset_product",   Product,  32'h0);
        check("reset_busy",      Busy,     1'b0);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            do_mult(vecs[i].a, vecs[i].b, 0, prod, lat);
            $display("[TB] vec %0d: A=0x%04h B=0x%04h P=0x%08h lat=%0d", i, vecs[i].a, vecs[i].b, prod, lat);
            check($sformatf("vec%0d_product", i), prod, vecs[i].p);
            check($sformatf("vec%0d_latency", i), lat, 9);
        end

        // Output stall for 20 cycles, with new operands offered during the stall
        InValid      = 1'b1;
        Multiplicant = 16'h1234;
        Multiplier   = 16'h0F0F;
        OutReady     = 1'b0;
        @(negedge clk);
        Multiplicant = 16'h0100;
        Multiplier   = 16'h0100;
        check("stall_in_ready_calc", InReady, 1'b0);
        n = 1;
        while (!OutValid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("stall_latency", n, 9);
        check("stall_product", Product, 32'h01121D0C);
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            check("stall_stable", {OutValid, InReady, Product}, {1'b1, 1'b0, 32'h01121D0C});
        end
        OutReady = 1'b1;
        @(negedge clk);
        check("stall_release_idle", {InReady, OutValid}, {1'b1, 1'b0});
        @(negedge clk);
        InValid = 1'b0;
        check("stall_next_accept", Busy, 1'b1);
        n = 1;
        while (!OutValid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("stall_next_latency", n, 9);
        check("stall_next_product", Product, 32'h00010000);
        $display("[TB] stall: held 20 cycles, next P=0x%08h", Product);
        @(negedge clk);

        // Reset during CALC cycle 4
        InValid      = 1'b1;
        Multiplicant = 16'h7FFF;
        Multiplier   = 16'h7FFF;
        @(negedge clk);
        InValid = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_in_calc", Busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_state", {InReady, OutValid, Busy, Product}, {1'b1, 1'b0, 1'b0, 32'h0});
        pulse = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (OutValid) pulse = 1'b1;
        end
        check("midrst_no_pulse", pulse, 1'b0);
        do_mult(16'h0002, 16'hFFFD, 0, prod, lat);
        $display("[TB] after reset: A=0x0002 B=0xFFFD P=0x%08h", prod);
        check("midrst_product", prod, 32'hFFFFFFFA);

        // Random pairs with random output stalls
        for (int k = 0; k < 300; k++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rexp = 32'($signed(ra) * $signed(rb));
            do_mult(ra, rb, int'($urandom_range(0, 3)), prod, lat);
            $display("[TB] rnd %0d: A=0x%04h B=0x%04h P=0x%08h", k, ra, rb, prod);
            check("rnd_product", prod, rexp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
